// File: rtl/window_pointer_stack.sv
// window_pointer_stack
// Register-window base pointer for the SAYEH register file, with a small
// hardware LIFO that saves the base on call (push) and restores it on
// return (pop). Sticky flags record misuse of the stack.
//
// Command strobes (WPadd/WPpush/WPpop/WPclrErr) are level-sampled on every
// rising clk edge. No handshake is involved: each cycle a strobe is high
// counts as one command, and the outcome is visible on the registered
// outputs one cycle later. When several strobes are high together the
// highest-priority one wins: push+pop together, then pop, then push, then add.
module window_pointer_stack #(
  parameter int WP_WIDTH = 3,
  parameter int DEPTH    = 4,
  parameter int SATURATE = 0,
  localparam int DW      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                WPreset,
  input  logic [WP_WIDTH-1:0] WPin,
  input  logic                WPadd,
  input  logic                WPpush,
  input  logic                WPpop,
  input  logic                WPclrErr,
  output logic [WP_WIDTH-1:0] WPout,
  output logic [DW-1:0]       WPdepth,
  output logic                WPfull,
  output logic                WPempty,
  output logic                WPovf,
  output logic                WPunf,
  output logic                WPerr
);

  logic [WP_WIDTH-1:0] wp_q, wp_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                err_q, err_d;

  // Save entries; contents are meaningless above depth_q, so no reset.
  logic [WP_WIDTH-1:0] lifo_q [DEPTH];

  logic                push_ok;
  logic [WP_WIDTH-1:0] top_val;
  logic [WP_WIDTH:0]   sum_wide;
  logic [WP_WIDTH-1:0] sum_val;

  // Pointer plus offset, one bit wider so saturation can see the carry.
  always_comb begin
    sum_wide = {1'b0, wp_q} + {1'b0, WPin};
    if ((SATURATE != 0) && sum_wide[WP_WIDTH]) begin
      sum_val = '1;
    end else begin
      sum_val = sum_wide[WP_WIDTH-1:0];
    end
  end

  // Select the most recently saved entry (index depth_q-1).
  always_comb begin
    top_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) begin
        top_val = lifo_q[i];
      end
    end
  end

  // Command decode; a flag set in the same cycle as WPclrErr stays set.
  always_comb begin
    wp_d    = wp_q;
    depth_d = depth_q;
    ovf_d   = ovf_q & ~WPclrErr;
    unf_d   = unf_q & ~WPclrErr;
    err_d   = err_q & ~WPclrErr;
    push_ok = 1'b0;

    if (WPpush && WPpop) begin
      err_d = 1'b1;
    end else if (WPpop) begin
      if (depth_q != '0) begin
        wp_d    = top_val;
        depth_d = depth_q - DW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (WPpush) begin
      if (depth_q != DW'(DEPTH)) begin
        push_ok = 1'b1;
        wp_d    = sum_val;
        depth_d = depth_q + DW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (WPadd) begin
      wp_d = sum_val;
    end
  end

  // Pointer, depth and sticky flags; reset may arrive at any time.
  always_ff @(posedge clk or posedge WPreset) begin
    if (WPreset) begin
      wp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      err_q   <= err_d;
    end
  end

  // Save the pre-add pointer into the first free slot on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (depth_q == DW'(i)) begin
          lifo_q[i] <= wp_q;
        end
      end
    end
  end

  assign WPout   = wp_q;
  assign WPdepth = depth_q;
  assign WPfull  = (depth_q == DW'(DEPTH));
  assign WPempty = (depth_q == '0);
  assign WPovf   = ovf_q;
  assign WPunf   = unf_q;
  assign WPerr   = err_q;

endmodule

// File: tb/tb_window_pointer_stack.sv
// Bench for window_pointer_stack (WP_WIDTH=3, DEPTH=4), with a second
// saturating instance sharing the same stimulus.
module tb_window_pointer_stack;

  logic       clk;
  logic       WPreset;
  logic [2:0] WPin;
  logic       WPadd, WPpush, WPpop, WPclrErr;

  logic [2:0] WPout;
  logic [2:0] WPdepth;
  logic       WPfull, WPempty, WPovf, WPunf, WPerr;

  logic [2:0] sat_wp;
  logic [2:0] sat_depth;
  logic       sat_full, sat_empty, sat_ovf, sat_unf, sat_err;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected pushed when a command is driven, observed pushed
  // one edge later; each test pops and compares both.
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];

  logic [10:0] obs;
  assign obs = {WPout, WPdepth, WPfull, WPempty, WPovf, WPunf, WPerr};

  window_pointer_stack #(.WP_WIDTH(3), .DEPTH(4), .SATURATE(0)) dut (
    .clk(clk), .WPreset(WPreset), .WPin(WPin), .WPadd(WPadd),
    .WPpush(WPpush), .WPpop(WPpop), .WPclrErr(WPclrErr),
    .WPout(WPout), .WPdepth(WPdepth), .WPfull(WPfull), .WPempty(WPempty),
    .WPovf(WPovf), .WPunf(WPunf), .WPerr(WPerr)
  );

  window_pointer_stack #(.WP_WIDTH(3), .DEPTH(4), .SATURATE(1)) dut_sat (
    .clk(clk), .WPreset(WPreset), .WPin(WPin), .WPadd(WPadd),
    .WPpush(WPpush), .WPpop(WPpop), .WPclrErr(WPclrErr),
    .WPout(sat_wp), .WPdepth(sat_depth), .WPfull(sat_full), .WPempty(sat_empty),
    .WPovf(sat_ovf), .WPunf(sat_unf), .WPerr(sat_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] mk_exp(input logic [2:0] wp, input logic [2:0] d,
                                         input logic ovf, input logic unf, input logic err);
    return {wp, d, (d == 3'd4), (d == 3'd0), ovf, unf, err};
  endfunction

  // Driver: one command per cycle, applied at negedge, sampled #1 after posedge.
  task automatic drive(input logic psh, input logic pp, input logic ad, input logic cl,
                       input logic [2:0] din, input logic [10:0] e);
    @(negedge clk);
    WPpush = psh; WPpop = pp; WPadd = ad; WPclrErr = cl; WPin = din;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back(obs);
    WPpush = 1'b0; WPpop = 1'b0; WPadd = 1'b0; WPclrErr = 1'b0; WPin = 3'd0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    WPreset = 1'b1;
    @(negedge clk);
    WPreset = 1'b0;
  endtask

  task automatic test_reset();
    WPreset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== mk_exp(3'd0, 3'd0, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_state: actual=%b required=%b (wp,depth,full,empty,ovf,unf,err)",
               obs, mk_exp(3'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    end
    checks++;
    if (sat_wp !== 3'd0) begin
      errors++;
      $display("FAIL reset_sat_wp: actual=%0d required=0", sat_wp);
    end
    WPreset = 1'b0;
  endtask

  task automatic test_add_wrap();
    logic [2:0] wrap_v [3];
    logic [2:0] sat_v [3];
    logic [10:0] e, o;
    wrap_v = '{3'd3, 3'd6, 3'd1};
    sat_v  = '{3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, mk_exp(wrap_v[i], 3'd0, 1'b0, 1'b0, 1'b0));
      checks++;
      if (sat_wp !== sat_v[i]) begin
        errors++;
        $display("FAIL add_saturate[%0d]: actual=%0d required=%0d", i, sat_wp, sat_v[i]);
      end
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL add_wrap[%0d]: actual=%b required=%b (wp,depth,full,empty,ovf,unf,err)", i, o, e);
      end
    end
  endtask

  task automatic test_push_pop();
    logic [10:0] e, o;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, mk_exp(3'd2, 3'd0, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd4, mk_exp(3'd6, 3'd1, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, mk_exp(3'd7, 3'd2, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, mk_exp(3'd6, 3'd1, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, mk_exp(3'd2, 3'd0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL push_pop[%0d]: actual=%b required=%b (wp,depth,full,empty,ovf,unf,err)", i, o, e);
      end
    end
  endtask

  task automatic test_overflow();
    logic [10:0] e, o;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, mk_exp(3'(i), 3'(i), 1'b0, 1'b0, 1'b0));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, mk_exp(3'd4, 3'd4, 1'b1, 1'b0, 1'b0));
    for (int i = 3; i >= 0; i--) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, mk_exp(3'(i), 3'(i), 1'b1, 1'b0, 1'b0));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, mk_exp(3'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL overflow[%0d]: actual=%b required=%b (wp,depth,full,empty,ovf,unf,err)", i, o, e);
      end
    end
  endtask

  task automatic test_underflow();
    logic [10:0] e, o;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd5, mk_exp(3'd5, 3'd0, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, mk_exp(3'd5, 3'd0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, mk_exp(3'd5, 3'd0, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, mk_exp(3'd5, 3'd0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, mk_exp(3'd5, 3'd0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL underflow[%0d]: actual=%b required=%b (wp,depth,full,empty,ovf,unf,err)", i, o, e);
      end
    end
  endtask

  task automatic test_push_pop_conflict();
    logic [10:0] e, o;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, mk_exp(3'd7, 3'd1, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, mk_exp(3'd0, 3'd2, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, mk_exp(3'd0, 3'd2, 1'b0, 1'b0, 1'b1));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, mk_exp(3'd7, 3'd1, 1'b0, 1'b0, 1'b1));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, mk_exp(3'd7, 3'd1, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, mk_exp(3'd7, 3'd1, 1'b0, 1'b0, 1'b1));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, mk_exp(3'd7, 3'd1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL push_pop_conflict[%0d]: actual=%b required=%b (wp,depth,full,empty,ovf,unf,err)", i, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] e, o;
    apply_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd2, mk_exp(3'd2, 3'd0, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, mk_exp(3'd3, 3'd1, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, mk_exp(3'd4, 3'd2, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, mk_exp(3'd5, 3'd3, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, mk_exp(3'd5, 3'd3, 1'b0, 1'b0, 1'b1));
    // Reset between edges: outputs must clear without waiting for clk.
    @(negedge clk);
    #2 WPreset = 1'b1;
    #1;
    checks++;
    if (obs !== mk_exp(3'd0, 3'd0, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL async_reset_now: actual=%b required=%b (wp,depth,full,empty,ovf,unf,err)",
               obs, mk_exp(3'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    end
    #1 WPreset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, mk_exp(3'd3, 3'd0, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, mk_exp(3'd3, 3'd0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL async_reset[%0d]: actual=%b required=%b (wp,depth,full,empty,ovf,unf,err)", i, o, e);
      end
    end
  endtask

  // Random back-to-back commands against a queue-based reference model.
  task automatic test_back_to_back();
    logic [2:0] m_wp;
    logic [2:0] m_stk[$];
    logic       m_ovf, m_unf, m_err;
    logic       psh, pp, ad, cl;
    logic [2:0] din;
    logic [10:0] e, o;
    apply_reset();
    m_wp = 3'd0; m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
    for (int n = 0; n < 300; n++) begin
      psh = ($urandom_range(0, 9) < 3);
      pp  = ($urandom_range(0, 9) < 3);
      ad  = ($urandom_range(0, 9) < 4);
      cl  = ($urandom_range(0, 9) < 1);
      din = 3'($urandom_range(0, 7));
      if (cl) begin
        m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
      end
      if (psh && pp) begin
        m_err = 1'b1;
      end else if (pp) begin
        if (m_stk.size() > 0) m_wp = m_stk.pop_back();
        else m_unf = 1'b1;
      end else if (psh) begin
        if (m_stk.size() < 4) begin
          m_stk.push_back(m_wp);
          m_wp = m_wp + din;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (ad) begin
        m_wp = m_wp + din;
      end
      drive(psh, pp, ad, cl, din, mk_exp(m_wp, 3'(m_stk.size()), m_ovf, m_unf, m_err));
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: actual=%b required=%b (wp,depth,full,empty,ovf,unf,err)", i, o, e);
      end
    end
  endtask

  initial begin
    WPreset = 1'b1; WPin = 3'd0;
    WPadd = 1'b0; WPpush = 1'b0; WPpop = 1'b0; WPclrErr = 1'b0;
    test_reset();
    test_add_wrap();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_push_pop_conflict();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_pointer_stack.md
# window_pointer_stack

Parametrised register-window pointer for the SAYEH datapath with a hardware save/restore stack. Holds the current window base for the register file. The pointer advances by a signed-agnostic offset, modulo 2^WP_WIDTH or saturating. Call/return sequences push the current base onto an internal LIFO and pop it back. Sits between the controller (WPreset/WPadd/WPpush/WPpop strobes) and the register-file address adder.

## Interface

- WP_WIDTH, 3, width of window pointer and offset input
- DEPTH, 4, number of LIFO save entries (≥1)
- SATURATE, 0, 0 = add wraps mod 2^WP_WIDTH; 1 = add clamps at 2^WP_WIDTH-1
- DW = $clog2(DEPTH+1), derived (localparam), width of depth count

Ports:

- clk  in  1  rising-edge clock
- WPreset  in  1  asynchronous, active-high reset
- WPin  in  WP_WIDTH  offset added to pointer (unsigned)
- WPadd  in  1  add WPin to pointer
- WPpush  in  1  save pointer to LIFO, then add WPin
- WPpop  in  1  restore pointer from LIFO top
- WPclrErr  in  1  synchronous clear of sticky error flags
- WPout  out  WP_WIDTH  current window pointer (registered)
- WPdepth  out  DW  number of valid LIFO entries (registered)
- WPfull  out  1  WPdepth == DEPTH
- WPempty  out  1  WPdepth == 0
- WPovf  out  1  sticky: push attempted while full
- WPunf  out  1  sticky: pop attempted while empty
- WPerr  out  1  sticky: push and pop asserted together

## Operation

- Reset (async, any time, including mid-sequence): WPout=0, WPdepth=0, WPovf=WPunf=WPerr=0. LIFO contents don't care. WPempty=1, WPfull=0.
- Per-cycle command decode, priority top-down:
  - WPpush & WPpop: no state change except WPerr←1. WPadd ignored.
  - WPpop: if depth>0, WPout←LIFO[depth-1], depth←depth-1. Else WPunf←1 and WPout unchanged. WPadd ignored.
  - WPpush: if depth<DEPTH, LIFO[depth]←WPout (pre-add value), depth←depth+1, WPout←sum(WPout,WPin). Else WPovf←1 and WPout/depth unchanged (no add). WPadd redundant.
  - WPadd alone: WPout←sum(WPout,WPin).
  - None: hold.
- sum: with SATURATE=0, (WPout+WPin) mod 2^WP_WIDTH. With SATURATE=1, min(WPout+WPin, 2^WP_WIDTH-1), computed at WP_WIDTH+1 bits.
- WPclrErr clears WPovf/WPunf/WPerr. If a new error event occurs in the same cycle, the set wins.
- WPfull/WPempty are decoded from the registered depth. No combinational path from inputs to any output.

## Timing

- All state updates occur on the rising clk edge following the strobe. Results are visible on WPout/WPdepth/flags one cycle after the strobe (latency 1).
- Back-to-back commands are supported every cycle. A pop directly after a push returns the value pushed.
- Push on the cycle depth reaches DEPTH-1 succeeds. The next push flags WPovf.
- Reset is asserted/deasserted asynchronously. The first command is accepted on the first edge after deassertion.
- Strobes are level-sampled. Holding a strobe for N cycles executes it N times.

## Test plan

- Reset then WPadd with WPin=3 for 3 cycles (WP_WIDTH=3, SATURATE=0) -> WPout 3, 6, 1 (wrap). With SATURATE=1 -> 3, 6, 7.
- WPout=2. Push WPin=4, push WPin=1, pop, pop -> WPout 6, 7, 6, 2. WPdepth 1, 2, 1, 0. WPempty=1 at end.
- DEPTH=4: five pushes with WPin=1 from 0 -> WPout 1..4, then 4 held. WPfull=1, WPovf=1 after the 5th. Four pops return 3, 2, 1, 0.
- Pop with depth 0 -> WPout unchanged, WPunf=1. Then WPclrErr -> WPunf=0 next cycle. WPclrErr coinciding with a new empty pop -> WPunf stays 1.
- WPpush & WPpop together at depth 2 -> WPout/WPdepth unchanged, WPerr=1.
- Assert WPreset asynchronously mid-edge-interval with depth 3, WPout=5 -> WPout=0, WPdepth=0, all flags 0 immediately, before the next clk edge.
